// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - byte-stream instruction memory loader with XOR checksum
module inst_mem_loader #(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              hold_cpu
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_WORD, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    state_t            state_q, state_d;
    logic [15:0]       len_q;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_inc;
    logic [1:0]        idx_q;
    logic [23:0]       sh_q;
    logic [7:0]        xor_q;
    logic [15:0]       len_full;
    logic              accept;
    logic              start_ok;

    logic              in_ready_q, busy_q, hold_q, done_q, err_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    assign accept   = in_valid && in_ready_q;
    assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    assign cnt_inc  = cnt_q + 1'b1;
    assign len_full = {len_q[15:8], in_data};

    // Status flags are a pure decode of the state being entered, so they land in registers.
    function automatic logic [4:0] flags(input state_t s);
        case (s)
            S_LEN_HI, S_LEN_LO, S_WORD, S_CSUM: flags = 5'b11100;
            S_DONE:                             flags = 5'b00010;
            S_ERR:                              flags = 5'b00101;
            default:                            flags = 5'b00000;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN_HI;
            S_LEN_HI: if (accept) state_d = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if (len_full > DEPTH16)      state_d = S_ERR;
                    else if (len_full == 16'd0)  state_d = S_CSUM;
                    else                         state_d = S_WORD;
                end
            end
            S_WORD: begin
                if (accept && idx_q == 2'd3 && 16'(cnt_inc) == len_q) state_d = S_CSUM;
            end
            S_CSUM: if (accept) state_d = (in_data == xor_q) ? S_DONE : S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_q        <= '0;
            xor_q       <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q  <= state_d;
            {in_ready_q, busy_q, hold_q, done_q, err_q} <= flags(state_d);
            mem_we_q <= 1'b0;
            if (start_ok) begin
                cnt_q <= '0;
                idx_q <= '0;
                xor_q <= '0;
            end
            if (accept) begin
                xor_q <= xor_q ^ in_data;
                case (state_q)
                    S_LEN_HI: len_q[15:8] <= in_data;
                    S_LEN_LO: len_q[7:0]  <= in_data;
                    S_WORD: begin
                        idx_q <= idx_q + 2'd1;
                        sh_q  <= {sh_q[15:0], in_data};
                        if (idx_q == 2'd3) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= cnt_q[ADDR_W-1:0];
                            mem_wdata_q <= {sh_q, in_data};
                            cnt_q       <= cnt_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign hold_cpu  = hold_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - randomized self-checking bench with stream-level reference model
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, mem_we, busy, done, err, hold_cpu;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;

    always #5 clk = ~clk;

    inst_mem_loader #(.ADDR_W(7), .DEPTH(128)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .hold_cpu(hold_cpu)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [38:0] exp_q[$];
    bit          exp_done, exp_err;
    int          exp_consumed;
    logic [7:0]  exp_x;
    int          wr_cnt;
    logic [31:0] tb_mem[128];
    logic [7:0]  stim[$];
    logic [7:0]  three[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference: what a whole stream must produce, derived from the byte format alone.
    function automatic void model(input logic [7:0] b[$]);
        int n;
        logic [7:0] x;
        n = int'({b[0], b[1]});
        exp_q.delete();
        x = b[0] ^ b[1];
        if (n > 128) begin
            exp_done = 1'b0;
            exp_err = 1'b1;
            exp_consumed = 2;
        end else begin
            for (int w = 0; w < n; w++) begin
                exp_q.push_back({7'(w), b[2+4*w], b[3+4*w], b[4+4*w], b[5+4*w]});
                for (int k = 0; k < 4; k++) x = x ^ b[2+4*w+k];
            end
            exp_done = (b[2+4*n] == x);
            exp_err = !exp_done;
            exp_consumed = 4*n + 3;
        end
        exp_x = x;
    endfunction

    task automatic build(input int n, input bit bad);
        logic [7:0] x;
        stim.delete();
        stim.push_back(8'(n >> 8));
        stim.push_back(8'(n));
        x = stim[0] ^ stim[1];
        if (n <= 128) begin
            for (int i = 0; i < 4*n; i++) begin
                stim.push_back(8'($urandom));
                x = x ^ stim[stim.size()-1];
            end
            stim.push_back(bad ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_hold_cpu"}, hold_cpu, 0);
    endtask

    always @(negedge clk) begin : compare
        logic [38:0] e;
        if (rst_n) begin
            chk("in_ready_eq_busy", in_ready, busy);
            chk("hold_rule", hold_cpu, busy | err);
            chk("done_err_excl", done & err, 0);
            if (mem_we) begin
                wr_cnt++;
                tb_mem[mem_addr] = mem_wdata;
                if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", mem_addr, e[38:32]);
                    chk("wr_data", mem_wdata, e[31:0]);
                end
            end
        end
    end

    // mode 0: in_valid held high, 1: valid every other cycle, 2: random gaps
    task automatic run_load(input logic [7:0] b[$], input int mode, input int rst_after);
        int idx, cyc;
        bit v, take;
        model(b);
        wr_cnt = 0;
        idx = 0;
        cyc = 0;
        @(negedge clk);
        start = 1'b1;
        in_valid = (mode != 1);
        in_data = b[0];
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_in_ready", in_ready, 1);
        chk("start_hold", hold_cpu, 1);
        chk("start_clears", {done, err}, 0);
        while (idx < exp_consumed && cyc < 4000) begin
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = (cyc % 2 == 0);
            else v = 1'($urandom_range(0, 1));
            in_valid = v;
            in_data = b[idx];
            take = v && in_ready;
            @(negedge clk);
            cyc++;
            if (take) idx++;
            if (rst_after != 0 && idx == rst_after) begin
                #1 rst_n = 1'b0;
                in_valid = 1'b0;
                #1 check_reset_vals("rst_mid");
                repeat (2) @(negedge clk);
                check_reset_vals("rst_hold");
                chk("rst_pending_words", exp_q.size(), 2);
                chk("rst_writes", wr_cnt, 1);
                chk("rst_word0", tb_mem[0], 32'h01896020);
                exp_q.delete();
                rst_n = 1'b1;
                return;
            end
        end
        in_valid = 1'b0;
        chk("accept_count", idx, exp_consumed);
        if (mode == 0) chk("cycles_full_rate", cyc, exp_consumed);
        if (mode == 1) chk("cycles_alternate", cyc, 2*exp_consumed - 1);
        chk("end_busy", busy, 0);
        chk("end_in_ready", in_ready, 0);
        chk("end_done", done, exp_done);
        chk("end_err", err, exp_err);
        chk("end_hold", hold_cpu, exp_err);
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("no_more_consumed_done", done, exp_done);
        chk("pending_writes", exp_q.size(), 0);
    endtask

    initial begin
        three = '{8'h00, 8'h03, 8'h01, 8'h89, 8'h60, 8'h20, 8'h15, 8'h8B,
                  8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h54};
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        model(three);
        chk("model_csum", exp_x, 8'h54);
        chk("model_nwords", exp_q.size(), 3);
        chk("model_w0", exp_q[0], {7'd0, 32'h01896020});
        chk("model_w1", exp_q[1], {7'd1, 32'h158BFFFE});
        chk("model_w2", exp_q[2], {7'd2, 32'h00000000});

        run_load(three, 0, 0);
        chk("three_writes", wr_cnt, 3);
        chk("three_mem1", tb_mem[1], 32'h158BFFFE);
        chk("three_done", done, 1);

        stim = '{8'h00, 8'h00, 8'h00};
        run_load(stim, 0, 0);
        chk("empty_writes", wr_cnt, 0);
        chk("empty_done", done, 1);

        stim = '{8'h00, 8'h81};
        run_load(stim, 0, 0);
        chk("oversize_writes", wr_cnt, 0);
        chk("oversize_err", {err, hold_cpu, in_ready}, 3'b110);

        stim = three;
        stim[14] = 8'h55;
        run_load(stim, 0, 0);
        chk("badcsum_writes", wr_cnt, 3);
        chk("badcsum_flags", {done, err, hold_cpu}, 3'b011);
        run_load(three, 0, 0);
        chk("recover_flags", {done, err, hold_cpu}, 3'b100);

        run_load(three, 1, 0);
        chk("bp_writes", wr_cnt, 3);
        chk("bp_done", done, 1);

        run_load(three, 0, 6);
        run_load(three, 0, 0);
        chk("after_rst_done", done, 1);

        build(128, 0);
        run_load(stim, 0, 0);
        chk("depth_writes", wr_cnt, 128);
        build(129, 0);
        run_load(stim, 2, 0);
        chk("depth_plus1_err", err, 1);

        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 7) == 0) build($urandom_range(129, 65535), 0);
            else build($urandom_range(0, 6), 1'($urandom_range(0, 1)));
            run_load(stim, (it % 2 == 0) ? 0 : 2, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
